// File: rtl/alu_mul_seq_if.sv
// rtl/alu_mul_seq_if.sv - start/done handshake bundle for the sequential multiplier
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     P;

  modport master (
    output start, is_signed, A, B,
    input  busy, done, P
  );

  modport slave (
    input  start, is_signed, A, B,
    output busy, done, P
  );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative radix-4 Booth multiplier, one digit per clock
// Optional early finish when remaining digits are zero: ALU_MUL_SEQ_EARLY_EXIT_EN
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         clear_n,
  alu_mul_seq_if.slave bus
);
  localparam int MW = WIDTH + 3;
  localparam int AW = 2 * WIDTH + 4;
  localparam int N  = WIDTH / 2 + 1;
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   mcand;
  logic [AW-1:0]   acc;
  logic [MW-1:0]   mplier;
  logic [CW-1:0]   count;

  logic [AW-1:0]   pp_mag;
  logic [AW-1:0]   pp;
  logic [AW-1:0]   sum;
  logic [MW-1:0]   mplier_next;
  logic            neg;
  logic            last;

  // mplier keeps b[-1] in bit 0, so the current digit is always mplier[2:0]
  always_comb begin
    pp_mag = '0;
    neg    = 1'b0;
    case (mplier[2:0])
      3'b001, 3'b010: pp_mag = mcand;
      3'b011:         pp_mag = mcand << 1;
      3'b100: begin
        pp_mag = mcand << 1;
        neg    = 1'b1;
      end
      3'b101, 3'b110: begin
        pp_mag = mcand;
        neg    = 1'b1;
      end
      default:        pp_mag = '0;
    endcase
    pp          = neg ? -pp_mag : pp_mag;
    sum         = acc + pp;
    mplier_next = {{2{mplier[MW-1]}}, mplier[MW-1:2]};
  end

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  // All-equal remaining bits (sign fill included) encode only zero digits
  assign last = (count == CW'(N - 1)) || (mplier_next == '0) || (&mplier_next);
`else
  assign last = (count == CW'(N - 1));
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.P    <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand    <= bus.is_signed ? {{(AW-WIDTH){bus.A[WIDTH-1]}}, bus.A}
                                      : {{(AW-WIDTH){1'b0}}, bus.A};
            mplier   <= {{2{bus.is_signed & bus.B[WIDTH-1]}}, bus.B, 1'b0};
            acc      <= '0;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc    <= sum;
          mcand  <= mcand << 2;
          mplier <= mplier_next;
          count  <= count + 1'b1;
          if (last) begin
            bus.P    <= sum[2*WIDTH-1:0];
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
